// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: the ALU writeback always wins, while loads are queued
// and drained in order. Defining WB_HAZARD_EN adds the read-address hazard ports.
module regfile_wb_arbiter #(
   parameter int bit_size   = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alu_we,
   input  logic [4:0]                  alu_addr,
   input  logic [bit_size-1:0]         alu_data,
   input  logic                        mem_valid,
   output logic                        mem_ready,
   input  logic [4:0]                  mem_addr,
   input  logic [bit_size-1:0]         mem_data,
`ifdef WB_HAZARD_EN
   input  logic [4:0]                  Read_addr_1,
   input  logic [4:0]                  Read_addr_2,
   output logic                        hazard_1,
   output logic                        hazard_2,
`endif
   output logic                        RegWrite,
   output logic [4:0]                  Write_addr,
   output logic [bit_size-1:0]         Write_data,
   output logic [$clog2(FIFO_DEPTH):0] pend_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [4:0]            addr_mem [FIFO_DEPTH];
   logic [bit_size-1:0]   data_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] live_q, live_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  we_q, we_d;
   logic [4:0]            waddr_q, waddr_d;
   logic [bit_size-1:0]   wdata_q, wdata_d;
   logic                  alu_req, accept, load_live, push, pop, direct;

   assign mem_ready = rst && (count_q < DEPTH_C);
   assign accept    = mem_valid && mem_ready;
   assign alu_req   = alu_we && (alu_addr != 5'd0);
   // A same-cycle ALU write to the same register is younger, so that load is dropped.
   assign load_live = accept && (mem_addr != 5'd0) && !(alu_req && (alu_addr == mem_addr));

   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      pop     = 1'b0;
      direct  = 1'b0;
      if (alu_req) begin
         we_d    = 1'b1;
         waddr_d = alu_addr;
         wdata_d = alu_data;
      end else if (count_q != '0) begin
         pop  = 1'b1;
         we_d = live_q[rd_ptr_q];
         if (live_q[rd_ptr_q]) begin
            waddr_d = addr_mem[rd_ptr_q];
            wdata_d = data_mem[rd_ptr_q];
         end
      end else if (load_live) begin
         direct  = 1'b1;
         we_d    = 1'b1;
         waddr_d = mem_addr;
         wdata_d = mem_data;
      end
      push     = load_live && !direct;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   // Live bits are cleared on pop so that a set bit always marks an occupied, unkilled slot.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_live
      assign live_d[gi] = (push && (wr_ptr_q == PW'(gi))) ||
                          (live_q[gi] &&
                           !(alu_req && (addr_mem[gi] == alu_addr)) &&
                           !(pop && (rd_ptr_q == PW'(gi))));
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= mem_addr;
         data_mem[wr_ptr_q] <= mem_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         live_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         live_q   <= live_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign RegWrite   = we_q;
   assign Write_addr = waddr_q;
   assign Write_data = wdata_q;
   assign pend_count = count_q;

`ifdef WB_HAZARD_EN
   logic [FIFO_DEPTH-1:0] q_hit_1, q_hit_2;
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hit
      assign q_hit_1[gi] = live_q[gi] && (addr_mem[gi] == Read_addr_1);
      assign q_hit_2[gi] = live_q[gi] && (addr_mem[gi] == Read_addr_2);
   end
   assign hazard_1 = rst && (Read_addr_1 != 5'd0) &&
                     ((|q_hit_1) || (we_q && (waddr_q == Read_addr_1)));
   assign hazard_2 = rst && (Read_addr_2 != 5'd0) &&
                     ((|q_hit_2) || (we_q && (waddr_q == Read_addr_2)));
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the writeback rules.
module tb_regfile_wb_arbiter;
   localparam int BS = 32;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          alu_we = 1'b0;
   logic [4:0]    alu_addr = '0;
   logic [BS-1:0] alu_data = '0;
   logic          mem_valid = 1'b0;
   logic          mem_ready;
   logic [4:0]    mem_addr = '0;
   logic [BS-1:0] mem_data = '0;
   logic          RegWrite;
   logic [4:0]    Write_addr;
   logic [BS-1:0] Write_data;
   logic [2:0]    pend_count;
`ifdef WB_HAZARD_EN
   logic [4:0]    Read_addr_1 = '0;
   logic [4:0]    Read_addr_2 = '0;
   logic          hazard_1, hazard_2;
`endif

   regfile_wb_arbiter #(.bit_size(BS), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef WB_HAZARD_EN
      .Read_addr_1(Read_addr_1), .Read_addr_2(Read_addr_2),
      .hazard_1(hazard_1), .hazard_2(hazard_2),
`endif
      .RegWrite(RegWrite), .Write_addr(Write_addr), .Write_data(Write_data),
      .pend_count(pend_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]    addr;
      logic [BS-1:0] data;
      bit            live;
   } entry_t;

   entry_t        q[$];
   bit            m_we;
   logic [4:0]    m_addr;
   logic [BS-1:0] m_data;
   bit            m_known;
   bit            last_acc;
   logic [BS-1:0] rf_dut [32];
   int            checks = 0;
   int            failures = 0;

   // Registers retired by the DUT, as the register file would see them.
   always @(posedge clk) if (rst && RegWrite) rf_dut[Write_addr] <= Write_data;

   task automatic model_reset();
      q.delete();
      m_we = 0; m_addr = '0; m_data = '0; m_known = 1;
   endtask

   // Drive one cycle of inputs, advance the reference model, then sample after the edge.
   task automatic step(input bit we, input logic [4:0] aa, input logic [BS-1:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [BS-1:0] md);
      bit alu, direct;
      entry_t e;
      @(negedge clk);
      alu_we = we; alu_addr = aa; alu_data = ad;
      mem_valid = mv; mem_addr = ma; mem_data = md;
      last_acc = mv && (q.size() < D);
      alu = we && (aa != 0);
      direct = 0;
      if (alu) begin
         foreach (q[i]) if (q[i].addr == aa) q[i].live = 0;
         m_we = 1; m_addr = aa; m_data = ad; m_known = 1;
      end else if (q.size() > 0) begin
         e = q.pop_front();
         m_we = e.live;
         if (e.live) begin m_addr = e.addr; m_data = e.data; end
         else m_known = 0;
      end else if (last_acc && ma != 0) begin
         m_we = 1; m_addr = ma; m_data = md; m_known = 1; direct = 1;
      end else begin
         m_we = 0;
      end
      if (last_acc && ma != 0 && !direct && !(alu && aa == ma))
         q.push_back('{addr: ma, data: md, live: 1'b1});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 5'd0, '0, 0, 5'd0, '0);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * D && q.size() > 0; i++) idle();
      idle();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         alu_we = 1'($urandom); alu_addr = 5'($urandom); alu_data = $urandom;
         mem_valid = 1'($urandom); mem_addr = 5'($urandom); mem_data = $urandom;
         @(posedge clk);
         #1;
         checks++;
         if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
         checks++;
         if (mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
         checks++;
         if (pend_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", pend_count); end
         checks++;
         if (Write_addr !== 5'd0 || Write_data !== '0) begin
            failures++; $display("FAIL reset_wport: got %0d/%0h want 0/0", Write_addr, Write_data);
         end
      end
      @(negedge clk);
      alu_we = 0; mem_valid = 0; alu_addr = '0; mem_addr = '0;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (mem_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", mem_ready); end
   endtask

   task automatic test_direct_load();
      step(0, 5'd0, '0, 1, 5'd5, 32'hA5);
      checks++;
      if (RegWrite !== 1'b1 || Write_addr !== 5'd5 || Write_data !== 32'hA5) begin
         failures++;
         $display("FAIL direct_load: got we=%b a=%0d d=%0h want we=1 a=5 d=a5", RegWrite, Write_addr, Write_data);
      end
      checks++;
      if (pend_count !== 3'd0) begin failures++; $display("FAIL direct_load_count: got %0d want 0", pend_count); end
   endtask

   task automatic test_addr0();
      step(0, 5'd0, '0, 1, 5'd6, 32'h5A5A);
      step(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
      checks++;
      if (RegWrite !== 1'b0) begin failures++; $display("FAIL addr0_regwrite: got %b want 0", RegWrite); end
      checks++;
      if (pend_count !== 3'd0) begin failures++; $display("FAIL addr0_count: got %0d want 0", pend_count); end
      checks++;
      if (Write_addr !== 5'd6 || Write_data !== 32'h5A5A) begin
         failures++; $display("FAIL addr0_hold: got %0d/%0h want 6/5a5a", Write_addr, Write_data);
      end
   endtask

   task automatic test_back_pressure();
      int acc_n = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 5'(20 + i), $urandom, 1, 5'(1 + i), 32'h100 + i);
         acc_n += int'(last_acc);
      end
      checks++;
      if (pend_count !== 3'd4 || mem_ready !== 1'b0) begin
         failures++; $display("FAIL bp_full: got count=%0d ready=%b want 4/0", pend_count, mem_ready);
      end
      checks++;
      if (acc_n != 4) begin failures++; $display("FAIL bp_model_accepts: got %0d want 4", acc_n); end
      for (int i = 0; i < 4; i++) begin
         idle();
         checks++;
         if (RegWrite !== 1'b1 || Write_addr !== 5'(1 + i) || Write_data !== 32'h100 + i) begin
            failures++;
            $display("FAIL bp_order%0d: got we=%b a=%0d d=%0h want we=1 a=%0d d=%0h",
                     i, RegWrite, Write_addr, Write_data, 1 + i, 32'h100 + i);
         end
      end
      checks++;
      if (pend_count !== 3'd0) begin failures++; $display("FAIL bp_drained: got %0d want 0", pend_count); end
   endtask

   task automatic test_kill();
      step(1, 5'd3, 32'h33, 1, 5'd7, 32'h11);
      checks++;
      if (pend_count !== 3'd1) begin failures++; $display("FAIL kill_queued: got %0d want 1", pend_count); end
      step(1, 5'd7, 32'h22, 0, 5'd0, '0);
      checks++;
      if (RegWrite !== 1'b1 || Write_addr !== 5'd7 || Write_data !== 32'h22) begin
         failures++; $display("FAIL kill_alu: got we=%b a=%0d d=%0h want 1/7/22", RegWrite, Write_addr, Write_data);
      end
      idle();
      checks++;
      if (RegWrite !== 1'b0 || pend_count !== 3'd0) begin
         failures++; $display("FAIL kill_pop: got we=%b count=%0d want 0/0", RegWrite, pend_count);
      end
      idle();
      checks++;
      if (rf_dut[7] !== 32'h22) begin failures++; $display("FAIL kill_rf7: got %0h want 22", rf_dut[7]); end
   endtask

`ifdef WB_HAZARD_EN
   task automatic test_hazard();
      Read_addr_1 = 5'd9;
      Read_addr_2 = 5'd0;
      step(1, 5'd3, 32'h1, 1, 5'd9, 32'h99);
      checks++;
      if (hazard_1 !== 1'b1 || hazard_2 !== 1'b0) begin
         failures++; $display("FAIL hazard_queued: got %b%b want 10", hazard_1, hazard_2);
      end
      idle();
      checks++;
      if (hazard_1 !== 1'b1 || RegWrite !== 1'b1 || Write_addr !== 5'd9) begin
         failures++; $display("FAIL hazard_pop: got hz=%b we=%b a=%0d want 1/1/9", hazard_1, RegWrite, Write_addr);
      end
      idle();
      checks++;
      if (hazard_1 !== 1'b0) begin failures++; $display("FAIL hazard_clear: got %b want 0", hazard_1); end
      Read_addr_1 = 5'd0;
   endtask
`endif

   task automatic test_random();
      int alu_pct;
      for (int n = 0; n < 400; n++) begin
         alu_pct = ((n / 50) % 2 == 0) ? 85 : 25;
         step($urandom_range(0, 99) < alu_pct, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
         checks++;
         if (RegWrite !== m_we) begin
            failures++; $display("FAIL rand_we[%0d]: got %b want %b", n, RegWrite, m_we);
         end
         checks++;
         if (pend_count !== 3'(q.size())) begin
            failures++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, pend_count, q.size());
         end
         checks++;
         if (mem_ready !== (q.size() < D)) begin
            failures++; $display("FAIL rand_ready[%0d]: got %b want %b", n, mem_ready, q.size() < D);
         end
         if (m_known) begin
            checks++;
            if (Write_addr !== m_addr || Write_data !== m_data) begin
               failures++;
               $display("FAIL rand_wport[%0d]: got %0d/%0h want %0d/%0h", n, Write_addr, Write_data, m_addr, m_data);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) step(1, 5'd30, $urandom, 1, 5'(10 + i), $urandom);
      @(negedge clk);
      alu_we = 0; mem_valid = 0;
      #2 rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (RegWrite !== 1'b0 || pend_count !== 3'd0 || mem_ready !== 1'b0) begin
         failures++;
         $display("FAIL midreset: got we=%b count=%0d ready=%b want 0/0/0", RegWrite, pend_count, mem_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle();
         checks++;
         if (RegWrite !== 1'b0 || pend_count !== 3'd0) begin
            failures++; $display("FAIL midreset_after%0d: got we=%b count=%0d want 0/0", i, RegWrite, pend_count);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_direct_load();
      test_addr0();
      drain();
      test_back_pressure();
      drain();
      test_kill();
      drain();
`ifdef WB_HAZARD_EN
      test_hazard();
      drain();
`endif
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
